// File: rtl/tu_split_scheduler.sv
// tu_split_scheduler: clamps the TU size to the CU and issues its TUs as coordinate commands over valid/ready.
// Optional macro TU_Z_ORDER_EN selects Z-order TU issue; undefined gives raster order.
module tu_split_scheduler #(
    parameter int unsigned X_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           cu_valid,
    output logic           cu_ready,
    input  logic [1:0]     cu_size,
    input  logic [X_W-1:0] cu_x,
    input  logic [X_W-1:0] cu_y,
    input  logic [1:0]     tsize_in,
    output logic           tu_valid,
    input  logic           tu_ready,
    output logic [X_W-1:0] tu_x,
    output logic [X_W-1:0] tu_y,
    output logic [1:0]     tu_size,
    output logic           tu_last,
    output logic           clamp_err,
    output logic           busy
);
    typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

    state_t         r_state;
    logic [X_W-1:0] r_cu_x;
    logic [X_W-1:0] r_cu_y;
    logic [2:0]     r_log2;
    logic [2:0]     r_nlog2;
    logic [7:0]     r_total_m1;
    logic [7:0]     r_idx;
    logic [X_W-1:0] r_tu_x;
    logic [X_W-1:0] r_tu_y;
    logic [1:0]     r_tu_size;
    logic           r_tu_last;
    logic           r_clamp;

    logic [2:0]     w_cu_log2;
    logic [2:0]     w_req_log2;
    logic [2:0]     w_eff_log2;
    logic [2:0]     w_eff_nlog2;
    logic           w_clamp;
    logic [7:0]     w_eff_total_m1;
    logic           w_accept;
    logic           w_hs;
    logic [7:0]     w_next_idx;
    logic [7:0]     w_p_idx;
    logic [2:0]     w_p_log2;
    logic [2:0]     w_p_nlog2;
    logic [7:0]     w_p_total_m1;
    logic [X_W-1:0] w_p_bx;
    logic [X_W-1:0] w_p_by;
    logic [3:0]     w_nmask;
    logic [3:0]     w_col;
    logic [3:0]     w_row;
    logic [X_W-1:0] w_nx;
    logic [X_W-1:0] w_ny;
    logic [1:0]     w_nsize;
    logic           w_nlast;

    assign cu_ready  = (r_state == ST_IDLE) & ~flush & ~rst;
    assign tu_valid  = (r_state == ST_ISSUE);
    assign busy      = (r_state == ST_ISSUE);
    assign tu_x      = r_tu_x;
    assign tu_y      = r_tu_y;
    assign tu_size   = r_tu_size;
    assign tu_last   = r_tu_last;
    assign clamp_err = r_clamp;

    assign w_accept = cu_valid & cu_ready;
    assign w_hs     = (r_state == ST_ISSUE) & tu_ready;

    // Effective size of an incoming CU: TU never larger than the CU itself.
    always_comb begin
        w_cu_log2      = 3'd3 + 3'(cu_size);
        w_req_log2     = 3'd2 + 3'(tsize_in);
        w_clamp        = (w_req_log2 > w_cu_log2);
        w_eff_log2     = w_clamp ? w_cu_log2 : w_req_log2;
        w_eff_nlog2    = w_cu_log2 - w_eff_log2;
        w_eff_total_m1 = 8'((9'd1 << 4'({w_eff_nlog2, 1'b0})) - 9'd1);
    end

    // Position of the TU to be presented next: index 0 of a new CU, or idx+1 of the current one.
    always_comb begin
        w_next_idx   = r_idx + 8'd1;
        w_p_idx      = w_accept ? 8'd0 : w_next_idx;
        w_p_log2     = w_accept ? w_eff_log2 : r_log2;
        w_p_nlog2    = w_accept ? w_eff_nlog2 : r_nlog2;
        w_p_total_m1 = w_accept ? w_eff_total_m1 : r_total_m1;
        w_p_bx       = w_accept ? cu_x : r_cu_x;
        w_p_by       = w_accept ? cu_y : r_cu_y;
        w_nmask      = 4'((5'd1 << w_p_nlog2) - 5'd1);
`ifdef TU_Z_ORDER_EN
        w_col        = {w_p_idx[6], w_p_idx[4], w_p_idx[2], w_p_idx[0]} & w_nmask;
        w_row        = {w_p_idx[7], w_p_idx[5], w_p_idx[3], w_p_idx[1]} & w_nmask;
`else
        w_col        = w_p_idx[3:0] & w_nmask;
        w_row        = 4'(w_p_idx >> w_p_nlog2);
`endif
        w_nx         = w_p_bx + (X_W'(w_col) << w_p_log2);
        w_ny         = w_p_by + (X_W'(w_row) << w_p_log2);
        w_nsize      = 2'(w_p_log2 - 3'd2);
        w_nlast      = (w_p_idx == w_p_total_m1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cu_x     <= '0;
            r_cu_y     <= '0;
            r_log2     <= '0;
            r_nlog2    <= '0;
            r_total_m1 <= '0;
            r_idx      <= '0;
            r_tu_x     <= '0;
            r_tu_y     <= '0;
            r_tu_size  <= '0;
            r_tu_last  <= 1'b0;
            r_clamp    <= 1'b0;
        end else begin
            if (w_accept && w_clamp) begin
                r_clamp <= 1'b1;
            end
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_state    <= ST_ISSUE;
                            r_cu_x     <= cu_x;
                            r_cu_y     <= cu_y;
                            r_log2     <= w_eff_log2;
                            r_nlog2    <= w_eff_nlog2;
                            r_total_m1 <= w_eff_total_m1;
                            r_idx      <= 8'd0;
                            r_tu_x     <= w_nx;
                            r_tu_y     <= w_ny;
                            r_tu_size  <= w_nsize;
                            r_tu_last  <= w_nlast;
                        end
                    end
                    ST_ISSUE: begin
                        if (w_hs) begin
                            if (r_tu_last) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_idx     <= w_next_idx;
                                r_tu_x    <= w_nx;
                                r_tu_y    <= w_ny;
                                r_tu_size <= w_nsize;
                                r_tu_last <= w_nlast;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tu_split_scheduler.sv
// Directed bench for tu_split_scheduler; build with TU_Z_ORDER_EN defined to exercise Z-order issue.
module tb_tu_split_scheduler;
    localparam int unsigned X_W = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           cu_valid;
    logic           cu_ready;
    logic [1:0]     cu_size;
    logic [X_W-1:0] cu_x;
    logic [X_W-1:0] cu_y;
    logic [1:0]     tsize_in;
    logic           tu_valid;
    logic           tu_ready;
    logic [X_W-1:0] tu_x;
    logic [X_W-1:0] tu_y;
    logic [1:0]     tu_size;
    logic           tu_last;
    logic           clamp_err;
    logic           busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    tu_split_scheduler #(.X_W(X_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cu_valid(cu_valid), .cu_ready(cu_ready), .cu_size(cu_size),
        .cu_x(cu_x), .cu_y(cu_y), .tsize_in(tsize_in),
        .tu_valid(tu_valid), .tu_ready(tu_ready),
        .tu_x(tu_x), .tu_y(tu_y), .tu_size(tu_size), .tu_last(tu_last),
        .clamp_err(clamp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one CU from IDLE and returns 1ns after the accepting edge.
    task automatic start_cu(input logic [1:0] sz, input int x, input int y, input logic [1:0] ts);
        cu_size  = sz;
        cu_x     = X_W'(x);
        cu_y     = X_W'(y);
        tsize_in = ts;
        cu_valid = 1'b1;
        #1;
        total_cnt++;
        if (cu_ready !== 1'b1) begin
            bad_cnt++;
            $display("FAIL start_cu_ready: got %b want 1", cu_ready);
        end
        step();
        cu_valid = 1'b0;
    endtask

    // Expected column/row of TU i in a CU with n TUs per side.
    function automatic int exp_col(input int i, input int n);
`ifdef TU_Z_ORDER_EN
        return (((i >> 6) & 1) << 3) | (((i >> 4) & 1) << 2) | (((i >> 2) & 1) << 1) | (i & 1);
`else
        return i % n;
`endif
    endfunction

    function automatic int exp_row(input int i, input int n);
`ifdef TU_Z_ORDER_EN
        return (((i >> 7) & 1) << 3) | (((i >> 5) & 1) << 2) | (((i >> 3) & 1) << 1) | ((i >> 1) & 1);
`else
        return i / n;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; cu_valid = 1'b0; tu_ready = 1'b1;
        cu_size = 2'd0; cu_x = '0; cu_y = '0; tsize_in = 2'd0;
        step();
        step();
        total_cnt++;
        if ({cu_ready, tu_valid, tu_last, clamp_err, busy} !== 5'b0 || tu_x !== '0 || tu_y !== '0 || tu_size !== 2'd0) begin
            bad_cnt++;
            $display("FAIL reset_vals: rdy=%b v=%b last=%b clamp=%b busy=%b x=%0d y=%0d sz=%0d want all 0",
                     cu_ready, tu_valid, tu_last, clamp_err, busy, tu_x, tu_y, tu_size);
        end
        rst = 1'b0;
        #1;
        total_cnt++;
        if (cu_ready !== 1'b1) begin
            bad_cnt++;
            $display("FAIL reset_release_ready: got %b want 1", cu_ready);
        end
    endtask

    task automatic test_single();
        tu_ready = 1'b1;
        start_cu(2'd2, 64, 32, 2'd3);
        total_cnt++;
        if (tu_valid !== 1'b1 || tu_x !== 12'd64 || tu_y !== 12'd32 || tu_size !== 2'd3 || tu_last !== 1'b1 || busy !== 1'b1 || cu_ready !== 1'b0) begin
            bad_cnt++;
            $display("FAIL single_tu: v=%b x=%0d y=%0d sz=%0d last=%b busy=%b rdy=%b want 1,64,32,3,1,1,0",
                     tu_valid, tu_x, tu_y, tu_size, tu_last, busy, cu_ready);
        end
        step();
        total_cnt++;
        if (tu_valid !== 1'b0 || cu_ready !== 1'b1 || busy !== 1'b0) begin
            bad_cnt++;
            $display("FAIL single_done: v=%b rdy=%b busy=%b want 0,1,0", tu_valid, cu_ready, busy);
        end
    endtask

    task automatic test_split();
        int ex, ey;
        tu_ready = 1'b1;
        start_cu(2'd1, 0, 0, 2'd0);
        for (int i = 0; i < 16; i++) begin
            ex = exp_col(i, 4) * 4;
            ey = exp_row(i, 4) * 4;
            total_cnt++;
            if (tu_valid !== 1'b1 || tu_x !== X_W'(ex) || tu_y !== X_W'(ey) || tu_size !== 2'd0 || tu_last !== (i == 15)) begin
                bad_cnt++;
                $display("FAIL split_tu%0d: v=%b x=%0d y=%0d sz=%0d last=%b want 1,%0d,%0d,0,%0d",
                         i, tu_valid, tu_x, tu_y, tu_size, tu_last, ex, ey, (i == 15));
            end
            step();
        end
        total_cnt++;
        if (tu_valid !== 1'b0 || cu_ready !== 1'b1) begin
            bad_cnt++;
            $display("FAIL split_end: v=%b rdy=%b want 0,1", tu_valid, cu_ready);
        end
    endtask

    task automatic test_clamp();
        tu_ready = 1'b1;
        start_cu(2'd0, 16, 8, 2'd2);
        total_cnt++;
        if (tu_valid !== 1'b1 || tu_x !== 12'd16 || tu_y !== 12'd8 || tu_size !== 2'd1 || tu_last !== 1'b1 || clamp_err !== 1'b1) begin
            bad_cnt++;
            $display("FAIL clamp_tu: v=%b x=%0d y=%0d sz=%0d last=%b clamp=%b want 1,16,8,1,1,1",
                     tu_valid, tu_x, tu_y, tu_size, tu_last, clamp_err);
        end
        step();
        total_cnt++;
        if (tu_valid !== 1'b0 || clamp_err !== 1'b1) begin
            bad_cnt++;
            $display("FAIL clamp_sticky: v=%b clamp=%b want 0,1", tu_valid, clamp_err);
        end
    endtask

    task automatic test_backpressure();
        int ex, ey;
        tu_ready = 1'b1;
        start_cu(2'd3, 128, 256, 2'd2);
        for (int i = 0; i < 16; i++) begin
            ex = 128 + exp_col(i, 4) * 16;
            ey = 256 + exp_row(i, 4) * 16;
            total_cnt++;
            if (tu_valid !== 1'b1 || tu_x !== X_W'(ex) || tu_y !== X_W'(ey) || tu_size !== 2'd2 || tu_last !== (i == 15)) begin
                bad_cnt++;
                $display("FAIL bp_tu%0d: v=%b x=%0d y=%0d sz=%0d last=%b want 1,%0d,%0d,2,%0d",
                         i, tu_valid, tu_x, tu_y, tu_size, tu_last, ex, ey, (i == 15));
            end
            if (i == 5) begin
                tu_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    total_cnt++;
                    if (tu_valid !== 1'b1 || tu_x !== X_W'(ex) || tu_y !== X_W'(ey) || tu_size !== 2'd2 || tu_last !== 1'b0) begin
                        bad_cnt++;
                        $display("FAIL bp_stall%0d: v=%b x=%0d y=%0d sz=%0d last=%b want 1,%0d,%0d,2,0",
                                 s, tu_valid, tu_x, tu_y, tu_size, tu_last, ex, ey);
                    end
                end
                tu_ready = 1'b1;
            end
            step();
        end
        total_cnt++;
        if (tu_valid !== 1'b0 || clamp_err !== 1'b1) begin
            bad_cnt++;
            $display("FAIL bp_end: v=%b clamp=%b want 0,1", tu_valid, clamp_err);
        end
    endtask

    task automatic test_flush_wrap();
        int ex [4] = '{4064, 0, 4064, 0};
        int ey [4] = '{0, 0, 32, 32};
        tu_ready = 1'b1;
        start_cu(2'd3, 0, 0, 2'd2);
        for (int i = 0; i < 6; i++) step();
        total_cnt++;
        if (tu_valid !== 1'b1 || tu_last !== 1'b0) begin
            bad_cnt++;
            $display("FAIL flush_pre: v=%b last=%b want 1,0", tu_valid, tu_last);
        end
        flush    = 1'b1;
        cu_valid = 1'b1;
        cu_size  = 2'd0;
        cu_x     = 12'd100;
        cu_y     = 12'd100;
        tsize_in = 2'd0;
        #1;
        total_cnt++;
        if (cu_ready !== 1'b0) begin
            bad_cnt++;
            $display("FAIL flush_ready: got %b want 0", cu_ready);
        end
        step();
        flush    = 1'b0;
        cu_valid = 1'b0;
        #1;
        total_cnt++;
        if (tu_valid !== 1'b0 || busy !== 1'b0 || cu_ready !== 1'b1 || clamp_err !== 1'b1) begin
            bad_cnt++;
            $display("FAIL flush_after: v=%b busy=%b rdy=%b clamp=%b want 0,0,1,1", tu_valid, busy, cu_ready, clamp_err);
        end
        step();
        total_cnt++;
        if (tu_valid !== 1'b0) begin
            bad_cnt++;
            $display("FAIL flush_not_accepted: v=%b want 0", tu_valid);
        end
        start_cu(2'd3, 4064, 0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (tu_valid !== 1'b1 || tu_x !== X_W'(ex[i]) || tu_y !== X_W'(ey[i]) || tu_size !== 2'd3 || tu_last !== (i == 3)) begin
                bad_cnt++;
                $display("FAIL wrap_tu%0d: v=%b x=%0d y=%0d sz=%0d last=%b want 1,%0d,%0d,3,%0d",
                         i, tu_valid, tu_x, tu_y, tu_size, tu_last, ex[i], ey[i], (i == 3));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        tu_ready = 1'b1;
        cu_size  = 2'd2;
        cu_x     = 12'd256;
        cu_y     = 12'd0;
        tsize_in = 2'd3;
        cu_valid = 1'b1;
        step();
        total_cnt++;
        if (tu_valid !== 1'b1 || tu_x !== 12'd256 || tu_last !== 1'b1 || cu_ready !== 1'b0) begin
            bad_cnt++;
            $display("FAIL b2b_first: v=%b x=%0d last=%b rdy=%b want 1,256,1,0", tu_valid, tu_x, tu_last, cu_ready);
        end
        cu_x = 12'd512;
        cu_y = 12'd64;
        step();
        total_cnt++;
        if (tu_valid !== 1'b0 || cu_ready !== 1'b1) begin
            bad_cnt++;
            $display("FAIL b2b_bubble: v=%b rdy=%b want 0,1", tu_valid, cu_ready);
        end
        step();
        cu_valid = 1'b0;
        total_cnt++;
        if (tu_valid !== 1'b1 || tu_x !== 12'd512 || tu_y !== 12'd64 || tu_last !== 1'b1 || clamp_err !== 1'b1) begin
            bad_cnt++;
            $display("FAIL b2b_second: v=%b x=%0d y=%0d last=%b clamp=%b want 1,512,64,1,1",
                     tu_valid, tu_x, tu_y, tu_last, clamp_err);
        end
        step();
    endtask

    task automatic test_reset_mid_cu();
        tu_ready = 1'b1;
        start_cu(2'd1, 32, 32, 2'd0);
        step();
        step();
        rst = 1'b1;
        step();
        total_cnt++;
        if ({tu_valid, busy, clamp_err, cu_ready, tu_last} !== 5'b0 || tu_x !== '0 || tu_y !== '0) begin
            bad_cnt++;
            $display("FAIL reset_mid: v=%b busy=%b clamp=%b rdy=%b last=%b x=%0d y=%0d want all 0",
                     tu_valid, busy, clamp_err, cu_ready, tu_last, tu_x, tu_y);
        end
        rst = 1'b0;
        step();
        total_cnt++;
        if (tu_valid !== 1'b0 || cu_ready !== 1'b1 || clamp_err !== 1'b0) begin
            bad_cnt++;
            $display("FAIL reset_mid_after: v=%b rdy=%b clamp=%b want 0,1,0", tu_valid, cu_ready, clamp_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_clamp();
        test_backpressure();
        test_flush_wrap();
        test_back_to_back();
        test_reset_mid_cu();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
